// File: rtl/risc_pkg.sv
// Shared ISA definitions for the 6-stage pipeline: opcodes, widths, sequencer states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package risc_pkg;

    // Datapath widths
    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 16;
    localparam int REG_IDX_W = 3;
    localparam int MASK_W    = 8;

    // Opcode map (instruction bits [15:12])
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_ADI = 4'b0001;
    localparam logic [3:0] OP_NDU = 4'b0010;
    localparam logic [3:0] OP_LHI = 4'b0011;
    localparam logic [3:0] OP_LW  = 4'b0100;
    localparam logic [3:0] OP_SW  = 4'b0101;
    localparam logic [3:0] OP_BEQ = 4'b1000;
    localparam logic [3:0] OP_JAL = 4'b1001;
    localparam logic [3:0] OP_JLR = 4'b1010;
    localparam logic [3:0] OP_LM  = 4'b1100;
    localparam logic [3:0] OP_SM  = 4'b1101;

    // LM/SM sequencer states
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    // Drop one register from a mask once its micro-op has been issued
    function automatic logic [MASK_W-1:0] clear_bit(input logic [MASK_W-1:0] mask,
                                                     input logic [REG_IDX_W-1:0] idx);
        logic [MASK_W-1:0] one_hot;
        one_hot   = '0;
        one_hot[idx] = 1'b1;
        return mask & ~one_hot;
    endfunction

endpackage

// File: rtl/lm_sm_sequencer_lsb_prio_enc8.sv
// Lowest-set-bit priority encoder: 8-bit mask -> 3-bit index plus any-set flag.
// Latency: purely combinational.
// Backpressure: none.
module lsb_prio_enc8
    import risc_pkg::*;
(
    input  logic [MASK_W-1:0]    mask,
    output logic [REG_IDX_W-1:0] idx,
    output logic                 any
);

    // Scan from the top down so the lowest set bit is the last (winning) assignment
    always_comb begin
        idx = '0;
        for (int i = MASK_W - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = REG_IDX_W'(i);
            end
        end
        any = |mask;
    end

endmodule

// File: rtl/lm_sm_sequencer.sv
// Cracks an LM/SM in the RR stage into one single-register memory micro-op per cycle.
// Latency: accept cycle issues nothing; N set mask bits -> N micro-ops on the N following unstalled cycles.
// Backpressure: stall_in holds the walk in place (freeze held); flush abandons it immediately.
module lm_sm_sequencer
    import risc_pkg::*;
#(
    parameter logic [3:0]        LM_OP     = OP_LM,
    parameter logic [3:0]        SM_OP     = OP_SM,
    parameter logic [ADDR_W-1:0] ADDR_STEP = 16'd1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [3:0]           opcode_rr,
    input  logic [MASK_W-1:0]    reg_mask,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic                 stall_in,
    input  logic                 flush,
    output logic                 freeze_seq,
    output logic                 uop_valid,
    output logic                 uop_is_store,
    output logic [REG_IDX_W-1:0] uop_reg,
    output logic [ADDR_W-1:0]    uop_addr,
    output logic                 done
);

    seq_state_t            state;
    logic [MASK_W-1:0]     rem_mask;
    logic [ADDR_W-1:0]     addr;
    logic                  kind;

    logic [REG_IDX_W-1:0]  sel_idx;
    logic                  sel_any;
    logic [MASK_W-1:0]     rem_next;
    logic                  is_lmsm;
    logic                  in_run;
    logic                  accept;
    logic                  issue;
    logic                  last;

    // Next register to issue is always the lowest one still pending
    lsb_prio_enc8 u_enc (
        .mask (rem_mask),
        .idx  (sel_idx),
        .any  (sel_any)
    );

    // Accept/issue decisions; these depend on same-cycle inputs so freeze and the
    // micro-op react in the cycle the pipeline presents the condition
    always_comb begin
        is_lmsm  = (opcode_rr == LM_OP) || (opcode_rr == SM_OP);
        in_run   = (state == RUN);
        accept   = (state == IDLE) && start && is_lmsm && (reg_mask != '0) && !flush;
        // sel_any is always set in RUN; gating on it keeps an empty mask from ever issuing
        issue    = in_run && sel_any && !stall_in && !flush;
        rem_next = clear_bit(rem_mask, sel_idx);
        last     = issue && (rem_next == '0);
    end

    // Output decode: micro-op fields are forced to zero whenever no micro-op is valid
    always_comb begin
        freeze_seq   = accept || (in_run && !flush && !last);
        uop_valid    = issue;
        uop_is_store = issue ? kind    : 1'b0;
        uop_reg      = issue ? sel_idx : '0;
        uop_addr     = issue ? addr    : '0;
        done         = last;
    end

    // Sequencer FSM with its mask register and address counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rem_mask <= '0;
            addr     <= '0;
            kind     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= RUN;
                        rem_mask <= reg_mask;
                        addr     <= base_addr;
                        kind     <= (opcode_rr == SM_OP);
                    end
                end
                RUN: begin
                    if (flush) begin
                        // Partial sequence is dropped; registers left for the next accept to overwrite
                        state    <= IDLE;
                        rem_mask <= '0;
                    end else if (issue) begin
                        rem_mask <= rem_next;
                        addr     <= addr + ADDR_STEP;
                        if (last) begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
module tb_lm_sm_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  opcode_rr;
    logic [7:0]  reg_mask;
    logic [15:0] base_addr;
    logic        stall_in;
    logic        flush;
    logic        freeze_seq;
    logic        uop_valid;
    logic        uop_is_store;
    logic [2:0]  uop_reg;
    logic [15:0] uop_addr;
    logic        done;

    lm_sm_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .opcode_rr    (opcode_rr),
        .reg_mask     (reg_mask),
        .base_addr    (base_addr),
        .stall_in     (stall_in),
        .flush        (flush),
        .freeze_seq   (freeze_seq),
        .uop_valid    (uop_valid),
        .uop_is_store (uop_is_store),
        .uop_reg      (uop_reg),
        .uop_addr     (uop_addr),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [3:0] LM = 4'b1100;
    localparam logic [3:0] SM = 4'b1101;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: pending micro-ops as a list of (register, address) pairs
    bit        m_busy = 1'b0;
    bit        m_kind = 1'b0;
    int        q_reg[$];
    int        q_addr[$];

    // Last observed output vector {valid, store, reg, addr, done, freeze}
    logic [22:0] obs;

    function automatic logic [22:0] pk(input logic v, input logic s, input logic [2:0] r,
                                       input logic [15:0] a, input logic d, input logic f);
        return {v, s, r, a, d, f};
    endfunction

    task automatic lit(input string name, input logic [22:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got v=%b st=%b r=%0d a=%h d=%b f=%b, want v=%b st=%b r=%0d a=%h d=%b f=%b",
                     name, obs[22], obs[21], obs[20:18], obs[17:2], obs[1], obs[0],
                     exp[22], exp[21], exp[20:18], exp[17:2], exp[1], exp[0]);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model
    task automatic step(input logic r, input logic s, input logic [3:0] op, input logic [7:0] m,
                        input logic [15:0] b, input logic st, input logic fl);
        logic [22:0] exp;
        bit acc, iss, lst;
        rst = r; start = s; opcode_rr = op; reg_mask = m; base_addr = b;
        stall_in = st; flush = fl;
        #2;
        exp = '0; acc = 0; iss = 0; lst = 0;
        if (!m_busy) begin
            acc = s && (op == LM || op == SM) && (m != 8'h00) && !fl;
            exp = pk(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, acc);
        end else if (!fl) begin
            if (st) begin
                exp = pk(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
            end else begin
                iss = 1;
                lst = (q_reg.size() == 1);
                exp = pk(1'b1, m_kind, 3'(q_reg[0]), 16'(q_addr[0]), lst, !lst);
            end
        end
        obs = {uop_valid, uop_is_store, uop_reg, uop_addr, done, freeze_seq};
        if (!r) begin
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL model cyc=%0d: got %h want %h", cyc, obs, exp);
            end
        end
        @(posedge clk);
        cyc++;
        if (r || (m_busy && fl)) begin
            m_busy = 0;
            q_reg.delete();
            q_addr.delete();
        end else if (m_busy) begin
            if (iss) begin
                void'(q_reg.pop_front());
                void'(q_addr.pop_front());
                if (q_reg.size() == 0) m_busy = 0;
            end
        end else if (acc) begin
            int k;
            k = 0;
            for (int i = 0; i < 8; i++) begin
                if (m[i]) begin
                    q_reg.push_back(i);
                    q_addr.push_back(int'(b + 16'(k)));
                    k++;
                end
            end
            m_kind = (op == SM);
            m_busy = 1;
        end
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'd0, 8'h00, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && m_busy; i++) idle();
        total++;
        if (m_busy) begin
            bad++;
            $display("FAIL drain: sequence still active after 40 cycles");
        end
    endtask

    localparam logic [22:0] ZERO = 23'h0;

    initial begin
        rst = 1'b1; start = 1'b0; opcode_rr = 4'd0; reg_mask = 8'h00;
        base_addr = 16'h0; stall_in = 1'b0; flush = 1'b0; obs = '0;

        step(1'b1, 1'b0, 4'd0, 8'h00, 16'h0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 4'd0, 8'h00, 16'h0, 1'b0, 1'b0);
        idle();
        lit("reset_outputs", ZERO);

        // LM 0x0100, mask A5
        step(1'b0, 1'b1, LM, 8'hA5, 16'h0100, 1'b0, 1'b0);
        lit("lm_accept", pk(0, 0, 3'd0, 16'h0, 0, 1));
        idle(); lit("lm_r0", pk(1, 0, 3'd0, 16'h0100, 0, 1));
        idle(); lit("lm_r2", pk(1, 0, 3'd2, 16'h0101, 0, 1));
        idle(); lit("lm_r5", pk(1, 0, 3'd5, 16'h0102, 0, 1));
        idle(); lit("lm_r7", pk(1, 0, 3'd7, 16'h0103, 1, 0));
        idle(); lit("lm_after", ZERO);

        // SM wrap
        step(1'b0, 1'b1, SM, 8'h03, 16'hFFFF, 1'b0, 1'b0);
        lit("sm_accept", pk(0, 0, 3'd0, 16'h0, 0, 1));
        idle(); lit("sm_r0", pk(1, 1, 3'd0, 16'hFFFF, 0, 1));
        idle(); lit("sm_r1_wrap", pk(1, 1, 3'd1, 16'h0000, 1, 0));

        // Stall hold
        step(1'b0, 1'b1, LM, 8'h0F, 16'h2000, 1'b0, 1'b0);
        idle(); lit("stall_r0", pk(1, 0, 3'd0, 16'h2000, 0, 1));
        step(1'b0, 1'b0, 4'd0, 8'h00, 16'h0, 1'b1, 1'b0); lit("stall_1", pk(0, 0, 3'd0, 16'h0, 0, 1));
        step(1'b0, 1'b0, 4'd0, 8'h00, 16'h0, 1'b1, 1'b0); lit("stall_2", pk(0, 0, 3'd0, 16'h0, 0, 1));
        idle(); lit("stall_r1", pk(1, 0, 3'd1, 16'h2001, 0, 1));
        idle(); lit("stall_r2", pk(1, 0, 3'd2, 16'h2002, 0, 1));
        idle(); lit("stall_r3", pk(1, 0, 3'd3, 16'h2003, 1, 0));

        // Flush on third micro-op
        step(1'b0, 1'b1, LM, 8'hFF, 16'h3000, 1'b0, 1'b0);
        idle(); idle();
        step(1'b0, 1'b0, 4'd0, 8'h00, 16'h0, 1'b0, 1'b1); lit("flush_cycle", ZERO);
        idle(); lit("flush_after", ZERO);
        step(1'b0, 1'b1, SM, 8'h81, 16'h3100, 1'b0, 1'b0);
        lit("post_flush_accept", pk(0, 0, 3'd0, 16'h0, 0, 1));
        drain();

        // Non-accepts
        step(1'b0, 1'b1, LM, 8'h00, 16'h1234, 1'b0, 1'b0); lit("na_mask0", ZERO);
        idle(); lit("na_mask0_next", ZERO);
        step(1'b0, 1'b1, 4'd0, 8'hFF, 16'h1234, 1'b0, 1'b0); lit("na_opcode0", ZERO);
        idle(); lit("na_opcode0_next", ZERO);
        step(1'b0, 1'b1, LM, 8'hFF, 16'h1234, 1'b0, 1'b1); lit("na_flush", ZERO);
        idle(); lit("na_flush_next", ZERO);

        // Reset mid-run
        step(1'b0, 1'b1, LM, 8'hF0, 16'h4000, 1'b0, 1'b0);
        idle(); lit("rst_r4", pk(1, 0, 3'd4, 16'h4000, 0, 1));
        step(1'b1, 1'b0, 4'd0, 8'h00, 16'h0, 1'b0, 1'b0);
        idle(); lit("rst_after", ZERO);
        step(1'b0, 1'b1, LM, 8'h06, 16'h5000, 1'b0, 1'b0);
        idle(); lit("fresh_r1", pk(1, 0, 3'd1, 16'h5000, 0, 1));
        idle(); lit("fresh_r2", pk(1, 0, 3'd2, 16'h5001, 1, 0));

        // Randomised traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic        r, s, st, fl;
            logic [3:0]  op;
            logic [7:0]  m;
            logic [15:0] b;
            r  = ($urandom_range(0, 199) == 0);
            s  = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0, 1: op = LM;
                2:    op = SM;
                default: op = 4'($urandom);
            endcase
            m  = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFF8, 16'hFFFF)) : 16'($urandom);
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 24) == 0);
            step(r, s, op, m, b, st, fl);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
